rsa: RTL and testbench

Self-contained RSA key-generation and round-trip block, used as the timing side-channel target in the design. From two primes `p` and `q` it derives the key pair (n, e, d). It then encrypts plaintext `m` and decrypts the ciphertext with modular square-and-multiply exponentiation, and reports the recovered plaintext. The exponentiation leaks the exponent through cycle count by default; this leakage is the object of study.

---
 rtl/rsa.sv | 275 +++++++++++++++++++++++++++
 tb/tb_rsa.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rsa.sv
// RSA key generation (n, e, d) followed by an encrypt/decrypt round trip of m.
// Define RSA_CONST_TIME_EN for exponent-independent exponentiation timing.
module rsa #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  input  logic             KeyGenStart,
  output logic [WIDTH-1:0] m_decrypted,
  output logic             finish
);
  localparam int W2 = 2 * WIDTH;
  localparam int TW = W2 + 2;
  localparam int CW = $clog2(W2 + 1);
  localparam int IW = $clog2(W2);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MODN = 3'd1;
  localparam logic [2:0] S_PHI  = 3'd2;
  localparam logic [2:0] S_ESEL = 3'd3;
  localparam logic [2:0] S_INV  = 3'd4;
  localparam logic [2:0] S_ENC  = 3'd5;
  localparam logic [2:0] S_DEC  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_DIV = CW'(W2 - 1);
  localparam logic [CW-1:0] CNT_MM  = CW'(W2);

  // KeyGenStart is a level request: sampled only in IDLE, and while it stays
  // high in DONE the result is held; dropping it returns the block to IDLE.
  logic [2:0]           state;
  logic [WIDTH-1:0]     p_r, q_r, m_r;
  logic [W2-1:0]        n_r, phi_r, e_r, d_r, c_r;
  logic [W2-1:0]        r1, div_q, div_rem;
  logic signed [TW-1:0] t0, t1;
  logic [W2-1:0]        mx, my, mr, acc;
  logic [IW-1:0]        idx;
  logic                 op;
  logic                 busy;
  logic [CW-1:0]        cnt;

  // Shift-add multiplier step (MODN / PHI)
  logic [W2-1:0] mul_nx;
  assign mul_nx = my[0] ? mr + mx : mr;

  // Restoring divider step: numerator shifts out of div_q, divisor is r1
  logic [W2:0]   div_shift;
  logic          div_ge;
  logic [W2-1:0] rem_nx, quot_nx;
  assign div_shift = {div_rem, div_q[W2-1]};
  assign div_ge    = div_shift >= {1'b0, r1};
  assign rem_nx    = div_ge ? W2'(div_shift - {1'b0, r1}) : div_shift[W2-1:0];
  assign quot_nx   = {div_q[W2-2:0], div_ge};

  // Extended Euclid coefficient update; magnitudes stay below phi so TW bits suffice
  logic signed [TW-1:0] t_nx;
  logic [W2-1:0]        d_fix;
  assign t_nx  = t0 - $signed({2'b00, quot_nx}) * t1;
  assign d_fix = W2'(t1 + $signed({2'b00, phi_r}));

  // Interleaved modular multiply step: r = 2r mod n, then + x mod n if y bit set
  logic [W2:0]   dbl, sum;
  logic [W2-1:0] dbl_red, mm_nx;
  assign dbl     = {mr, 1'b0};
  assign dbl_red = (dbl >= {1'b0, n_r}) ? W2'(dbl - {1'b0, n_r}) : dbl[W2-1:0];
  assign sum     = {1'b0, dbl_red} + (my[W2-1] ? {1'b0, mx} : {(W2+1){1'b0}});
  assign mm_nx   = (sum >= {1'b0, n_r}) ? W2'(sum - {1'b0, n_r}) : sum[W2-1:0];

  logic [W2-1:0] exp_val, base_val;
  logic          exp_bit;
  assign exp_val  = (state == S_DEC) ? d_r : e_r;
  assign base_val = (state == S_DEC) ? c_r : {{WIDTH{1'b0}}, m_r};
  assign exp_bit  = exp_val[idx];

`ifndef RSA_CONST_TIME_EN
  function automatic logic [IW-1:0] msb_idx(input logic [W2-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < W2; i++) begin
      if (v[i]) r = i[IW-1:0];
    end
    return r;
  endfunction
`endif

  // Decide what follows a finished modular multiply
  logic [W2-1:0] exp_acc_nx;
  logic          exp_op_nx, exp_last;
  always_comb begin
    exp_acc_nx = mm_nx;
    exp_op_nx  = 1'b0;
    exp_last   = 1'b0;
`ifdef RSA_CONST_TIME_EN
    if (!op) begin
      exp_op_nx = 1'b1;
    end else begin
      if (!exp_bit) exp_acc_nx = acc;
      exp_last = (idx == '0);
    end
`else
    if (!op && exp_bit) exp_op_nx = 1'b1;
    else                exp_last  = (idx == '0);
`endif
  end

  logic invalid;
  assign invalid = (p_r < WIDTH'(2)) || (q_r < WIDTH'(2)) || (p_r == q_r) ||
                   ({{WIDTH{1'b0}}, m_r} >= n_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      p_r <= '0; q_r <= '0; m_r <= '0;
      n_r <= '0; phi_r <= '0; e_r <= '0; d_r <= '0; c_r <= '0;
      r1 <= '0; div_q <= '0; div_rem <= '0;
      t0 <= '0; t1 <= '0;
      mx <= '0; my <= '0; mr <= '0; acc <= '0;
      idx <= '0; op <= 1'b0; busy <= 1'b0; cnt <= '0;
      m_decrypted <= '0;
      finish <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (KeyGenStart) begin
            p_r   <= p;
            q_r   <= q;
            m_r   <= m;
            mx    <= {{WIDTH{1'b0}}, p};
            my    <= {{WIDTH{1'b0}}, q};
            mr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_MODN;
          end
        end
        S_MODN, S_PHI: begin
          mr  <= mul_nx;
          mx  <= mx << 1;
          my  <= my >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_MUL) begin
            cnt <= '0;
            mr  <= '0;
            if (state == S_MODN) begin
              n_r   <= mul_nx;
              mx    <= {{WIDTH{1'b0}}, p_r - WIDTH'(1)};
              my    <= {{WIDTH{1'b0}}, q_r - WIDTH'(1)};
              state <= S_PHI;
            end else if (invalid) begin
              m_decrypted <= '0;
              finish      <= 1'b1;
              state       <= S_DONE;
            end else begin
              phi_r <= mul_nx;
              e_r   <= W2'(3);
              busy  <= 1'b0;
              state <= S_ESEL;
            end
          end
        end
        S_ESEL: begin
          if (!busy) begin
            if (e_r >= phi_r) begin
              m_decrypted <= '0;
              finish      <= 1'b1;
              state       <= S_DONE;
            end else begin
              r1      <= e_r;
              div_q   <= phi_r;
              div_rem <= '0;
              cnt     <= '0;
              busy    <= 1'b1;
            end
          end else begin
            div_q   <= quot_nx;
            div_rem <= rem_nx;
            cnt     <= cnt + 1'b1;
            if (cnt == CNT_DIV) begin
              cnt     <= '0;
              div_rem <= '0;
              if (rem_nx == '0) begin
                // gcd is the last non-zero remainder
                if (r1 == W2'(1)) begin
                  r1    <= e_r;
                  div_q <= phi_r;
                  t0    <= '0;
                  t1    <= TW'(1);
                  state <= S_INV;
                end else begin
                  e_r  <= e_r + W2'(2);
                  busy <= 1'b0;
                end
              end else begin
                div_q <= r1;
                r1    <= rem_nx;
              end
            end
          end
        end
        S_INV: begin
          div_q   <= quot_nx;
          div_rem <= rem_nx;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_DIV) begin
            cnt     <= '0;
            div_rem <= '0;
            if (rem_nx == '0) begin
              d_r   <= t1[TW-1] ? d_fix : t1[W2-1:0];
              busy  <= 1'b0;
              state <= S_ENC;
            end else begin
              div_q <= r1;
              r1    <= rem_nx;
              t0    <= t1;
              t1    <= t_nx;
            end
          end
        end
        S_ENC, S_DEC: begin
          if (!busy) begin
            acc  <= W2'(1);
            cnt  <= '0;
            busy <= 1'b1;
`ifdef RSA_CONST_TIME_EN
            idx  <= IW'(W2 - 1);
            op   <= 1'b0;
`else
            // first significant bit: 1*base, the square of 1 is skipped
            idx  <= msb_idx(exp_val);
            op   <= 1'b1;
`endif
          end else if (cnt == '0) begin
            mx  <= op ? base_val : acc;
            my  <= acc;
            mr  <= '0;
            cnt <= CW'(1);
          end else begin
            mr  <= mm_nx;
            my  <= my << 1;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MM) begin
              cnt <= '0;
              acc <= exp_acc_nx;
              op  <= exp_op_nx;
              if (exp_last) begin
                busy <= 1'b0;
                if (state == S_ENC) begin
                  c_r   <= exp_acc_nx;
                  state <= S_DEC;
                end else begin
                  m_decrypted <= exp_acc_nx[WIDTH-1:0];
                  finish      <= 1'b1;
                  state       <= S_DONE;
                end
              end else if (!exp_op_nx) begin
                idx <= idx - 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (!KeyGenStart) begin
            finish <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa.sv
// Self-checking bench for rsa: directed key cases plus random prime pairs,
// checked against an arithmetic RSA model and exponentiation cycle formulas.
module tb_rsa;
  localparam int WIDTH  = 8;
  localparam int MM_CYC = 2 * WIDTH + 1;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ENC  = 3'd5;
  localparam logic [2:0] ST_DEC  = 3'd6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] p, q, m;
  logic             KeyGenStart;
  logic [WIDTH-1:0] m_decrypted;
  logic             finish;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          primes[$];
  int          enc_cyc = 0, dec_cyc = 0, kg_cyc = 0;

  rsa #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p          (p),
    .q          (q),
    .m          (m),
    .KeyGenStart(KeyGenStart),
    .m_decrypted(m_decrypted),
    .finish     (finish)
  );

  // clock / reset
  always #5 clk = ~clk;

  // per-phase cycle counters, cleared whenever the block sits in IDLE
  always @(negedge clk) begin
    if (dut.state == ST_IDLE) begin
      enc_cyc = 0; dec_cyc = 0; kg_cyc = 0;
    end else if (dut.state == ST_ENC) enc_cyc++;
    else if (dut.state == ST_DEC) dec_cyc++;
    else if (dut.state >= 3'd1 && dut.state <= 3'd4) kg_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // reference model
  function automatic longint gcd_f(longint a, longint b);
    longint t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic longint pow_mod(longint b, longint e, longint n);
    longint r = 1;
    b = b % n;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % n;
      b = (b * b) % n;
      e = e / 2;
    end
    return r % n;
  endfunction

  function automatic int exp_cycles(longint e);
`ifdef RSA_CONST_TIME_EN
    return 2 * (2 * WIDTH) * MM_CYC + 1;
`else
    int bits = 0, ones = 0;
    while (e > 0) begin bits++; ones += int'(e % 2); e = e / 2; end
    return (bits + ones - 1) * MM_CYC + 1;
`endif
  endfunction

  task automatic ref_model(input int pp, input int qq, input int mm,
                           output bit ok, output longint e, output longint d);
    longint n = longint'(pp) * qq;
    longint phi = longint'(pp - 1) * (qq - 1);
    ok = (pp >= 2) && (qq >= 2) && (pp != qq) && (mm < n);
    e = 0; d = 0;
    if (ok) begin
      e = 3;
      while (e < phi && gcd_f(e, phi) != 1) e += 2;
      if (e >= phi) ok = 0;
    end
    if (ok) begin
      for (longint k = 1; k < phi; k++) begin
        if ((e * k) % phi == 1) begin d = k; break; end
      end
    end
  endtask

  // driver: one full start/finish transaction, with optional hold in DONE
  task automatic run_case(input int pp, input int qq, input int mm, input string tag, input int hold);
    bit          ok;
    longint      e, d, n;
    int          cyc;
    logic [31:0] expv;
    ref_model(pp, qq, mm, ok, e, d);
    n = longint'(pp) * qq;
    exp_q.push_back(ok ? 32'(pow_mod(pow_mod(mm, e, n), d, n) % 256) : 32'd0);
    @(negedge clk);
    p = pp[WIDTH-1:0]; q = qq[WIDTH-1:0]; m = mm[WIDTH-1:0];
    KeyGenStart = 1'b1;
    @(negedge clk);
    p = WIDTH'($urandom); q = WIDTH'($urandom); m = WIDTH'($urandom);
    cyc = 0;
    while (finish !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
    expv = exp_q.pop_front();
    check({tag, "_finish"}, 32'(finish), 32'd1);
    check({tag, "_result"}, 32'(m_decrypted), expv);
    check({tag, "_kg_bound"}, 32'(kg_cyc <= 64 * WIDTH * WIDTH), 32'd1);
    if (ok) begin
      check({tag, "_enc_cyc"}, 32'(enc_cyc), 32'(exp_cycles(e)));
      check({tag, "_dec_cyc"}, 32'(dec_cyc), 32'(exp_cycles(d)));
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_hold_finish"}, 32'(finish), 32'd1);
      check({tag, "_hold_result"}, 32'(m_decrypted), expv);
    end
    KeyGenStart = 1'b0;
    @(negedge clk);
    check({tag, "_drop_finish"}, 32'(finish), 32'd0);
    check({tag, "_drop_result"}, 32'(m_decrypted), expv);
  endtask

  initial begin
    int a, b, cyc;
    longint n;
    bit isp;
    for (int i = 2; i < (1 << WIDTH); i++) begin
      isp = 1;
      for (int j = 2; j * j <= i; j++) if (i % j == 0) isp = 0;
      if (isp) primes.push_back(i);
    end

    rst_n = 1'b0; KeyGenStart = 1'b0; p = '0; q = '0; m = '0;
    repeat (3) @(negedge clk);
    check("reset_finish", 32'(finish), 32'd0);
    check("reset_result", 32'(m_decrypted), 32'd0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));
    rst_n = 1'b1;

    run_case(11, 13, 7, "k11_13", 0);
    run_case(3, 11, 4, "k3_11", 5);
    run_case(1, 13, 5, "inv_p1", 0);
    run_case(7, 7, 3, "inv_peq", 0);
    run_case(2, 3, 1, "inv_noe", 0);
    run_case(11, 13, 150, "inv_mbig", 0);
    run_case(251, 241, 200, "k251_241", 0);

    // reset in the middle of encryption
    @(negedge clk);
    p = 8'd11; q = 8'd13; m = 8'd7; KeyGenStart = 1'b1;
    cyc = 0;
    while (dut.state != ST_ENC && cyc < 5000) begin @(negedge clk); cyc++; end
    check("midrst_reach_enc", 32'(dut.state), 32'(ST_ENC));
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_finish", 32'(finish), 32'd0);
    check("midrst_result", 32'(m_decrypted), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    KeyGenStart = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_case(11, 13, 7, "after_rst", 0);

    // random prime pairs
    for (int t = 0; t < 8; t++) begin
      a = $urandom_range(0, primes.size() - 1);
      b = $urandom_range(0, primes.size() - 1);
      if (a == b) b = (a + 1) % primes.size();
      n = longint'(primes[a]) * primes[b];
      run_case(primes[a], primes[b],
               $urandom_range(0, (n - 1 < 255) ? int'(n - 1) : 255),
               $sformatf("rnd%0d_%0d_%0d", t, primes[a], primes[b]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
